// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared mode and FSM state types for the registered decoder
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_PULSE = 2'b01,
    MODE_THERM = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    PULSE = 2'b10
  } state_e;

endpackage

// File: rtl/decoder_n_comb.sv
// rtl/decoder_n_comb.sv - combinational one-hot / thermometer decoder with enable
module decoder_n_comb #(
  parameter int SEL_W = 3,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en_in,
  input  logic             therm,
  output logic [OUT_W-1:0] vec
);

  always_comb begin
    vec = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (therm) begin
        vec[i] = en_in && (SEL_W'(i) <= sel);
      end else begin
        vec[i] = en_in && (SEL_W'(i) == sel);
      end
    end
  end

endmodule

// File: rtl/decoder_n_seq.sv
// rtl/decoder_n_seq.sv - registered decoder with valid/ready intake and level, pulse and thermometer modes
module decoder_n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int PULSE_W = 4,
  localparam int OUT_W  = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               en_in,
  input  logic [1:0]         mode,
  input  logic [PULSE_W-1:0] pulse_len,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               busy
);

  state_e             state, state_next;
  logic [PULSE_W-1:0] cnt, cnt_next;
  logic [OUT_W-1:0]   out_next;
  logic               valid_next;
  logic               accept;
  logic               is_therm;
  logic               start_pulse;
  logic [PULSE_W-1:0] pulse_load;
  logic [OUT_W-1:0]   dec_vec;

  assign in_ready    = (state != PULSE);
  assign busy        = (state == PULSE);
  assign accept      = in_valid && in_ready;
  assign is_therm    = (mode == MODE_THERM);
  assign start_pulse = en_in && (mode == MODE_PULSE);
  // A zero length still produces one pulse cycle rather than a dropped strobe.
  assign pulse_load  = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;

  decoder_n_comb #(
    .SEL_W (SEL_W)
  ) u_comb (
    .sel   (sel),
    .en_in (en_in),
    .therm (is_therm),
    .vec   (dec_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      out       <= out_next;
      out_valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    out_next   = out;
    valid_next = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          valid_next = 1'b1;
          out_next   = dec_vec;
          if (start_pulse) begin
            state_next = PULSE;
            cnt_next   = pulse_load;
          end else begin
            state_next = HOLD;
          end
        end
      end
      PULSE: begin
        // cnt counts the pulse cycles still to show, including the current one.
        if (cnt <= PULSE_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          out_next   = '0;
        end else begin
          cnt_next = cnt - PULSE_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        out_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_n_seq.sv
// tb/tb_decoder_n_seq.sv - directed and randomized bench for decoder_n_seq against a cycle-level model
module tb_decoder_n_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic       en_in;
  logic [1:0] mode;
  logic [3:0] pulse_len;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_out;
  logic       exp_valid;
  int         pulse_left;

  decoder_n_seq #(
    .SEL_W   (3),
    .PULSE_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .en_in     (en_in),
    .mode      (mode),
    .pulse_len (pulse_len),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"},       32'(out),       32'(exp_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, ".busy"},      32'(busy),      32'(pulse_left > 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(pulse_left == 0));
  endtask

  function automatic logic [7:0] ref_vec(input logic [2:0] s, input logic [1:0] m);
    int v;
    if (m == 2'b10) v = (1 << (int'(s) + 1)) - 1;
    else            v = 1 << int'(s);
    return 8'(v);
  endfunction

  // One clock: drive inputs, advance the model at the edge, check just after it.
  task automatic cyc(input string tag, input logic v, input logic [2:0] s, input logic e,
                     input logic [1:0] m, input logic [3:0] l);
    in_valid  = v;
    sel       = s;
    en_in     = e;
    mode      = m;
    pulse_len = l;
    @(posedge clk);
    if (!rst_n) begin
      exp_out    = '0;
      exp_valid  = 1'b0;
      pulse_left = 0;
    end else if (v && pulse_left == 0) begin
      exp_valid = 1'b1;
      if (!e) begin
        exp_out = '0;
      end else begin
        exp_out = ref_vec(s, m);
        if (m == 2'b01) pulse_left = (l == 0) ? 1 : int'(l);
      end
    end else begin
      exp_valid = 1'b0;
      if (pulse_left > 0) begin
        pulse_left--;
        if (pulse_left == 0) exp_out = '0;
      end
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    exp_out    = '0;
    exp_valid  = 1'b0;
    pulse_left = 0;
    cyc("reset", 1'b0, 3'd0, 1'b0, 2'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);

    cyc("lvl5", 1'b1, 3'd5, 1'b1, 2'b00, 4'd0);
    chk("lvl5.value", 32'(out), 32'h20);
    cyc("lvl5_hold0", 1'b0, 3'd1, 1'b1, 2'b10, 4'd9);
    cyc("lvl5_hold1", 1'b0, 3'd2, 1'b0, 2'b01, 4'd3);

    cyc("therm3", 1'b1, 3'd3, 1'b1, 2'b10, 4'd0);
    chk("therm3.value", 32'(out), 32'h0f);
    cyc("therm7", 1'b1, 3'd7, 1'b1, 2'b10, 4'd0);
    chk("therm7.value", 32'(out), 32'hff);

    cyc("pulse3", 1'b1, 3'd2, 1'b1, 2'b01, 4'd3);
    chk("pulse3.value", 32'(out), 32'h04);
    for (int i = 0; i < 3; i++) cyc("pulse3_ign", 1'b1, 3'd6, 1'b1, 2'b00, 4'd0);
    chk("pulse3.end", 32'(out), 32'h00);
    cyc("pulse3_idle", 1'b0, 3'd0, 1'b0, 2'b00, 4'd0);

    cyc("pulse0", 1'b1, 3'd1, 1'b1, 2'b01, 4'd0);
    cyc("pulse0_end", 1'b0, 3'd0, 1'b0, 2'b00, 4'd0);
    chk("pulse0.busy", 32'(busy), 32'd0);

    cyc("pulse15", 1'b1, 3'd7, 1'b1, 2'b01, 4'd15);
    for (int i = 0; i < 16; i++) cyc("pulse15_run", 1'b0, 3'd0, 1'b0, 2'b00, 4'd0);
    chk("pulse15.end", 32'(out), 32'h00);

    for (int m = 0; m < 4; m++) cyc("en0", 1'b1, 3'd6, 1'b0, 2'(m), 4'd5);

    cyc("rstpulse", 1'b1, 3'd4, 1'b1, 2'b01, 4'd10);
    cyc("rstpulse_c2", 1'b0, 3'd0, 1'b0, 2'b00, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out", 32'(out), 32'h00);
    chk("async_rst.busy", 32'(busy), 32'd0);
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    exp_out    = '0;
    exp_valid  = 1'b0;
    pulse_left = 0;
    cyc("in_reset", 1'b0, 3'd0, 1'b0, 2'b00, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_rst", 1'b0, 3'd4, 1'b1, 2'b01, 4'd10);

    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          ($urandom_range(0, 2) != 0),
          3'($urandom_range(0, 7)),
          ($urandom_range(0, 7) != 0),
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
